exu_mc_stage: RTL

//  Parametrised execute-stage pipeline register between IDU and MEM, with valid/allowin handshake, flush and exception pass-through.

---
 rtl/exu_pkg.sv | 19 +
 rtl/exu_mc_tracker.sv | 81 ++++++++
 rtl/exu_mc_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/exu_pkg.sv
// Shared definitions for the multi-cycle execute stage.
//   EXCP_W_DEF  default exception-code width
//   MC_MUL/DIV  bit positions of the multiplier and divider in mc_sel/mc_start/mc_done
//   byp_ctl_t   control half of the bypass bus to the IDU (data travels separately)
package exu_pkg;
    localparam int EXCP_W_DEF = 16;
    localparam int GPR_IDX_W  = 5;

    localparam int MC_MUL = 0;
    localparam int MC_DIV = 1;

    typedef struct packed {
        logic                 we;
        logic [GPR_IDX_W-1:0] dest;
        logic                 ready;
    } byp_ctl_t;

    localparam int BYP_CTL_W = $bits(byp_ctl_t);
endpackage

// File: rtl/exu_mc_tracker.sv
// Multi-cycle unit tracker for the instruction held in the execute stage.
// Keeps the unit select, raises the level start request until the unit's
// done pulse, latches the unit result, and selects the final result.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drops the held request and any latched result
//   advance             stage register is being overwritten this cycle
//   load, load_sel      a new instruction enters, with its unit select
//   valid, excp         held instruction is valid / carries an exception
//   mc_done, mc_result  unit completion pulses and result buses
//   alu_result          ALU result for instructions that use no unit
//   mc_start            per-unit level start request
//   ready_go            held instruction may leave the stage this cycle
//   result              final result of the held instruction
module exu_mc_tracker
    import exu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_MC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     advance,
    input  logic                     load,
    input  logic [NUM_MC-1:0]        load_sel,
    input  logic                     valid,
    input  logic                     excp,
    input  logic [NUM_MC-1:0]        mc_done,
    input  logic [NUM_MC*DATA_W-1:0] mc_result,
    input  logic [DATA_W-1:0]        alu_result,
    output logic [NUM_MC-1:0]        mc_start,
    output logic                     ready_go,
    output logic [DATA_W-1:0]        result
);
    logic [NUM_MC-1:0] sel;
    logic              done_lat;
    logic [DATA_W-1:0] res_lat;
    logic [DATA_W-1:0] mc_mux;
    logic [NUM_MC-1:0] hit;

    // Only a done from the selected unit of a live instruction counts;
    // late pulses after a flush and pulses from other units fall out here.
    assign hit = mc_done & sel & {NUM_MC{valid}};

    // sel is one-hot, so an OR of masked slices is the unit mux.
    always_comb begin
        mc_mux = '0;
        for (int i = 0; i < NUM_MC; i++) begin
            if (sel[i]) begin
                mc_mux = mc_mux | mc_result[i*DATA_W +: DATA_W];
            end
        end
    end

    // Drop the request in the done cycle itself so a unit never sees a
    // second start for the same instruction.
    assign mc_start = sel & ~mc_done & {NUM_MC{valid & ~done_lat & ~excp & ~flush}};
    assign ready_go = excp | ~(|sel) | done_lat | (|hit);
    assign result   = ~(|sel) ? alu_result : (done_lat ? res_lat : mc_mux);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            sel      <= '0;
            done_lat <= 1'b0;
            res_lat  <= '0;
        end else if (advance) begin
            sel      <= load ? load_sel : '0;
            done_lat <= 1'b0;
        end else if ((|hit) && !done_lat) begin
            done_lat <= 1'b1;
            res_lat  <= mc_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && load) begin
            assert ($onehot0(load_sel));
        end
    end
endmodule

// File: rtl/exu_mc_stage.sv
// Execute-stage pipeline register between IDU and MEM for N multi-cycle units.
// Handshake: a stage moves data when valid & allowin are both high on the
// same clock edge; valid never depends on the receiver's allowin, and a
// stage holds its data stable while valid is high and allowin is low.
// Ports:
//   clk, rst, flush                 clock, sync active-high reset, pipeline flush
//   in_valid/in_allowin             upstream handshake
//   in_payload/mc_sel/gr_we/dest/excp/excp_num  instruction fields
//   alu_result                      ALU result for the held instruction
//   mc_start/mc_done/mc_result      multi-cycle unit interface
//   out_valid/out_allowin           downstream handshake
//   out_payload/result/gr_we/dest/excp/excp_num registered instruction fields
//   byp_we/dest/data/ready          bypass to IDU (ready=0: data not final)
//   excp_up                         held instruction carries an exception
// Build option EXU_SKID_EN: adds a one-entry output skid register, which
// removes the combinational out_allowin -> in_allowin path.
module exu_mc_stage
    import exu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 128,
    parameter int NUM_MC    = 2,
    parameter int EXCP_W    = EXCP_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_allowin,
    input  logic [PAYLOAD_W-1:0]     in_payload,
    input  logic [NUM_MC-1:0]        in_mc_sel,
    input  logic                     in_gr_we,
    input  logic [4:0]               in_dest,
    input  logic                     in_excp,
    input  logic [EXCP_W-1:0]        in_excp_num,
    input  logic [DATA_W-1:0]        alu_result,
    output logic [NUM_MC-1:0]        mc_start,
    input  logic [NUM_MC-1:0]        mc_done,
    input  logic [NUM_MC*DATA_W-1:0] mc_result,
    output logic                     out_valid,
    input  logic                     out_allowin,
    output logic [PAYLOAD_W-1:0]     out_payload,
    output logic [DATA_W-1:0]        out_result,
    output logic                     out_gr_we,
    output logic [4:0]               out_dest,
    output logic                     out_excp,
    output logic [EXCP_W-1:0]        out_excp_num,
    output logic                     byp_we,
    output logic [4:0]               byp_dest,
    output logic [DATA_W-1:0]        byp_data,
    output logic                     byp_ready,
    output logic                     excp_up
);
    logic                 valid;
    logic [PAYLOAD_W-1:0] payload;
    logic                 gr_we;
    logic [4:0]           dest;
    logic                 excp;
    logic [EXCP_W-1:0]    excp_num;
    logic                 ready_go;
    logic                 load;
    logic                 stage_out_valid;
    logic [DATA_W-1:0]    result;

    assign load            = in_valid & in_allowin;
    assign stage_out_valid = valid & ready_go & ~flush;

    exu_mc_tracker #(
        .DATA_W (DATA_W),
        .NUM_MC (NUM_MC)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .advance    (in_allowin),
        .load       (load),
        .load_sel   (in_mc_sel),
        .valid      (valid),
        .excp       (excp),
        .mc_done    (mc_done),
        .mc_result  (mc_result),
        .alu_result (alu_result),
        .mc_start   (mc_start),
        .ready_go   (ready_go),
        .result     (result)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid    <= 1'b0;
            payload  <= '0;
            gr_we    <= 1'b0;
            dest     <= '0;
            excp     <= 1'b0;
            excp_num <= '0;
        end else if (in_allowin) begin
            valid <= in_valid;
            if (in_valid) begin
                payload  <= in_payload;
                gr_we    <= in_gr_we;
                dest     <= in_dest;
                excp     <= in_excp;
                excp_num <= in_excp_num;
            end
        end
    end

    // The bypass always describes the instruction in the stage register,
    // the youngest one this block holds.
    byp_ctl_t             byp;
    logic [BYP_CTL_W-1:0] byp_bits;
    assign byp.we    = valid & gr_we & ~excp;
    assign byp.dest  = dest;
    assign byp.ready = valid & ready_go;
    assign byp_bits  = byp;
    assign {byp_we, byp_dest, byp_ready} = byp_bits;
    assign byp_data  = result;
    assign excp_up   = valid & excp;

`ifdef EXU_SKID_EN
    logic                 skid_full;
    logic [PAYLOAD_W-1:0] skid_payload;
    logic [DATA_W-1:0]    skid_result;
    logic                 skid_gr_we;
    logic [4:0]           skid_dest;
    logic                 skid_excp;
    logic [EXCP_W-1:0]    skid_excp_num;

    // The stage hands off to MEM or, if MEM stalls, into the skid entry;
    // either way it only needs the skid to be empty to move.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            skid_full     <= 1'b0;
            skid_payload  <= '0;
            skid_result   <= '0;
            skid_gr_we    <= 1'b0;
            skid_dest     <= '0;
            skid_excp     <= 1'b0;
            skid_excp_num <= '0;
        end else if (skid_full) begin
            if (out_allowin) begin
                skid_full <= 1'b0;
            end
        end else if (stage_out_valid && !out_allowin) begin
            skid_full     <= 1'b1;
            skid_payload  <= payload;
            skid_result   <= result;
            skid_gr_we    <= gr_we;
            skid_dest     <= dest;
            skid_excp     <= excp;
            skid_excp_num <= excp_num;
        end
    end

    assign in_allowin   = ~valid | (ready_go & ~skid_full);
    assign out_valid    = skid_full ? ~flush : stage_out_valid;
    assign out_payload  = skid_full ? skid_payload  : payload;
    assign out_result   = skid_full ? skid_result   : result;
    assign out_gr_we    = skid_full ? skid_gr_we    : gr_we;
    assign out_dest     = skid_full ? skid_dest     : dest;
    assign out_excp     = skid_full ? skid_excp     : excp;
    assign out_excp_num = skid_full ? skid_excp_num : excp_num;
`else
    assign in_allowin   = ~valid | (ready_go & out_allowin);
    assign out_valid    = stage_out_valid;
    assign out_payload  = payload;
    assign out_result   = result;
    assign out_gr_we    = gr_we;
    assign out_dest     = dest;
    assign out_excp     = excp;
    assign out_excp_num = excp_num;
`endif
endmodule
